// File: rtl/sdram_ch1_arbiter.sv
// Arbitrates the SDRAM controller's 64-bit burst channel (ch1) between NREQ
// requesters: fixed priority with starvation boost, read skew capture, watchdog.
module sdram_ch1_starve #(
    parameter int LIMIT = 4,
    parameter int CW    = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic arb,
    input  logic req,
    input  logic win,
    output logic starved
);
    logic [CW-1:0] cnt;

    assign starved = req && (cnt >= CW'(LIMIT));

    // Counts arbitrations lost while requesting; saturates at LIMIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (arb) begin
            if (win)
                cnt <= '0;
            else if (req && cnt < CW'(LIMIT))
                cnt <= cnt + 1'b1;
        end
    end
endmodule

module sdram_ch1_arbiter #(
    parameter int NREQ         = 3,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255,
    parameter int RD_SKEW      = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      rq_req,
    input  logic [NREQ-1:0]      rq_rnw,
    input  logic [NREQ*26-1:0]   rq_addr,
    input  logic [NREQ*64-1:0]   rq_din,
    input  logic [NREQ*8-1:0]    rq_be,
    output logic [NREQ-1:0]      rq_ack,
    output logic [63:0]          rq_dout,
    output logic                 rq_err,
    output logic                 mem_req,
    output logic                 mem_rnw,
    output logic [26:1]          mem_addr,
    output logic [63:0]          mem_din,
    output logic [7:0]           mem_be,
    input  logic [63:0]          mem_dout,
    input  logic                 mem_ready,
    output logic                 busy
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SKEW, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   winner, sel;
    logic [NREQ-1:0] starved, win_oh, ack_oh;
    logic [7:0]      wdog, skew_cnt;
    logic            arb;

    assign arb    = (state == IDLE) && (|rq_req);
    assign ack_oh = NREQ'(1) << winner;

    // Starved requesters pre-empt plain fixed priority; lowest index wins either way.
    always_comb begin
        sel = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (rq_req[i]) sel = IW'(i);
        if (|starved)
            for (int i = NREQ - 1; i >= 0; i--)
                if (starved[i]) sel = IW'(i);
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_lane
        assign win_oh[g] = (sel == IW'(g));
        sdram_ch1_starve #(.LIMIT(STARVE_LIMIT), .CW(CW)) u_starve (
            .clk     (clk),
            .reset_n (reset_n),
            .arb     (arb),
            .req     (rq_req[g]),
            .win     (win_oh[g]),
            .starved (starved[g])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            winner   <= '0;
            wdog     <= '0;
            skew_cnt <= '0;
            rq_ack   <= '0;
            rq_dout  <= '0;
            rq_err   <= 1'b0;
            mem_req  <= 1'b0;
            mem_rnw  <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            mem_be   <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (arb) begin
                    winner   <= sel;
                    mem_rnw  <= rq_rnw[sel];
                    mem_addr <= rq_addr[26*sel +: 26];
                    mem_din  <= rq_din[64*sel +: 64];
                    mem_be   <= rq_be[8*sel +: 8];
                    mem_req  <= 1'b1;
                    busy     <= 1'b1;
                    state    <= ISSUE;
                end
                ISSUE: begin
                    mem_req <= 1'b0;
                    wdog    <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    wdog     <= wdog + 1'b1;
                    skew_cnt <= '0;
                    // A ready in the expiry cycle still wins over the timeout.
                    if (mem_ready) begin
                        if (!mem_rnw || RD_SKEW == 0) begin
                            if (mem_rnw) rq_dout <= mem_dout;
                            rq_ack <= ack_oh;
                            state  <= DONE;
                        end else
                            state <= SKEW;
                    end else if (wdog == 8'(TIMEOUT - 1)) begin
                        rq_err <= 1'b1;
                        rq_ack <= ack_oh;
                        state  <= DONE;
                    end
                end
                SKEW: begin
                    // Controller pulses ready before the last read word lands.
                    if (skew_cnt == 8'(RD_SKEW - 1)) begin
                        rq_dout <= mem_dout;
                        rq_ack  <= ack_oh;
                        state   <= DONE;
                    end else
                        skew_cnt <= skew_cnt + 1'b1;
                end
                DONE: begin
                    rq_ack <= '0;
                    rq_err <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_ch1_arbiter.sv
// Directed bench for sdram_ch1_arbiter; expected transactions are queued when
// stimulus is driven and checked by a monitor on every mem_req and rq_ack.
module tb_sdram_ch1_arbiter;
    localparam int NREQ    = 3;
    localparam int RD_SKEW = 1;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [NREQ-1:0]      rq_req = '0;
    logic [NREQ-1:0]      rq_rnw = '0;
    logic [NREQ*26-1:0]   rq_addr = '0;
    logic [NREQ*64-1:0]   rq_din = '0;
    logic [NREQ*8-1:0]    rq_be = '0;
    logic [NREQ-1:0]      rq_ack;
    logic [63:0]          rq_dout;
    logic                 rq_err;
    logic                 mem_req, mem_rnw;
    logic [26:1]          mem_addr;
    logic [63:0]          mem_din;
    logic [7:0]           mem_be;
    logic [63:0]          mem_dout = '0;
    logic                 mem_ready = 1'b0;
    logic                 busy;

    sdram_ch1_arbiter #(.NREQ(NREQ), .STARVE_LIMIT(4), .TIMEOUT(255), .RD_SKEW(RD_SKEW)) dut (
        .clk(clk), .reset_n(reset_n), .rq_req(rq_req), .rq_rnw(rq_rnw), .rq_addr(rq_addr),
        .rq_din(rq_din), .rq_be(rq_be), .rq_ack(rq_ack), .rq_dout(rq_dout), .rq_err(rq_err),
        .mem_req(mem_req), .mem_rnw(mem_rnw), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_be(mem_be), .mem_dout(mem_dout), .mem_ready(mem_ready), .busy(busy)
    );

    typedef struct {
        logic [NREQ-1:0] ack;
        logic [63:0]     dout;
        logic            err;
        logic            rnw;
        logic [25:0]     addr;
        logic [63:0]     din;
        logic [7:0]      be;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   mreq_cnt = 0;
    int   ord [11] = '{0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 2};

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed cycle %0d required completion", cyc);
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic drive(input int r, input logic rnw, input logic [25:0] a,
                         input logic [63:0] d, input logic [7:0] b);
        rq_rnw[r]          = rnw;
        rq_addr[26*r +: 26] = a;
        rq_din[64*r +: 64]  = d;
        rq_be[8*r +: 8]     = b;
    endtask

    task automatic expect_txn(input int r, input logic [63:0] dout, input logic err);
        exp_t x;
        x.ack  = NREQ'(1) << r;
        x.dout = dout;
        x.err  = err;
        x.rnw  = rq_rnw[r];
        x.addr = rq_addr[26*r +: 26];
        x.din  = rq_din[64*r +: 64];
        x.be   = rq_be[8*r +: 8];
        sb.push_back(x);
    endtask

    task automatic wait_mem_req(input string tag, output int at);
        int n = 0;
        do begin @(negedge clk); n++; end while (!mem_req && n < 50);
        at = cyc;
        if (!mem_req) check({tag, "_mem_req_timeout"}, 64'(mem_req), 64'd1);
    endtask

    task automatic wait_ack(input string tag, input int budget, output int at);
        int n = 0;
        do begin @(negedge clk); n++; end while (rq_ack == '0 && n < budget);
        at = cyc;
        if (rq_ack == '0) check({tag, "_ack_timeout"}, 64'(rq_ack), 64'd1);
    endtask

    // Pulse ready in WAIT cycle k; read data only becomes valid the cycle after.
    task automatic respond(input int k, input logic [63:0] d, input logic rd, output int at);
        repeat (k) @(posedge clk);
        #1 mem_ready = 1'b1;
        mem_dout = 64'hBAD0_BAD0_BAD0_BAD0;
        at = cyc;
        @(posedge clk);
        #1 mem_ready = 1'b0;
        if (rd) mem_dout = d;
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_req) begin
                mreq_cnt++;
                if (sb.size() == 0)
                    check("spurious_mem_req", 64'(mem_req), 64'd0);
                else begin
                    check("req_rnw",  64'(mem_rnw),  64'(sb[0].rnw));
                    check("req_addr", 64'(mem_addr), 64'(sb[0].addr));
                    check("req_din",  mem_din,       sb[0].din);
                    check("req_be",   64'(mem_be),   64'(sb[0].be));
                end
            end
            if (rq_ack != '0) begin
                if (sb.size() == 0)
                    check("spurious_ack", 64'(rq_ack), 64'd0);
                else begin
                    e = sb.pop_front();
                    check("ack",      64'(rq_ack),   64'(e.ack));
                    check("dout",     rq_dout,       e.dout);
                    check("err",      64'(rq_err),   64'(e.err));
                    check("ack_addr", 64'(mem_addr), 64'(e.addr));
                    check("ack_din",  mem_din,       e.din);
                    check("ack_be",   64'(mem_be),   64'(e.be));
                end
            end
        end
    end

    initial begin
        int t_rdy, t_ack, t_req;
        t_ack = 0;

        repeat (3) @(negedge clk);
        check("rst_ack",  64'(rq_ack),   64'd0);
        check("rst_dout", rq_dout,       64'd0);
        check("rst_err",  64'(rq_err),   64'd0);
        check("rst_mreq", 64'(mem_req),  64'd0);
        check("rst_rnw",  64'(mem_rnw),  64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_din",  mem_din,       64'd0);
        check("rst_be",   64'(mem_be),   64'd0);
        check("rst_busy", 64'(busy),     64'd0);
        @(posedge clk); #1 reset_n = 1'b1;

        // single read, requester 1
        drive(1, 1'b1, 26'h0123456, 64'h0, 8'hFF);
        expect_txn(1, 64'h1111_2222_3333_4444, 1'b0);
        mreq_cnt = 0;
        rq_req[1] = 1'b1;
        wait_mem_req("t1", t_req);
        respond(6, 64'h1111_2222_3333_4444, 1'b1, t_rdy);
        wait_ack("t1", 10, t_ack);
        rq_req[1] = 1'b0;
        check("t1_ack_latency", 64'(t_ack - t_rdy), 64'(RD_SKEW + 1));
        @(negedge clk);
        check("t1_mem_req_count", 64'(mreq_cnt), 64'd1);
        check("t1_busy_after", 64'(busy), 64'd0);

        // all three requesting and held: starvation boost order
        for (int r = 0; r < NREQ; r++) drive(r, 1'b1, 26'(32'h100 + r), 64'h0, 8'hFF);
        for (int k = 0; k < 11; k++) expect_txn(ord[k], 64'hC0DE_0000_0000_0000 + 64'(k), 1'b0);
        rq_req = 3'b111;
        for (int k = 0; k < 11; k++) begin
            wait_mem_req("t2", t_req);
            if (k == 1) check("t2_turnaround", 64'(t_req - t_ack), 64'd2);
            respond(1, 64'hC0DE_0000_0000_0000 + 64'(k), 1'b1, t_rdy);
            wait_ack("t2", 10, t_ack);
        end
        rq_req = '0;

        // write from requester 2; rq_dout must keep the last read data
        drive(2, 1'b0, 26'h2ABCDEF, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
        expect_txn(2, 64'hC0DE_0000_0000_000A, 1'b0);
        rq_req[2] = 1'b1;
        wait_mem_req("t3", t_req);
        respond(3, 64'h0, 1'b0, t_rdy);
        wait_ack("t3", 10, t_ack);
        rq_req[2] = 1'b0;
        check("t3_ack_latency", 64'(t_ack - t_rdy), 64'd1);

        // read timeout, then a stale ready in IDLE
        drive(0, 1'b1, 26'h0000ABC, 64'h0, 8'hFF);
        expect_txn(0, 64'hC0DE_0000_0000_000A, 1'b1);
        rq_req[0] = 1'b1;
        wait_mem_req("t4", t_req);
        wait_ack("t4", 300, t_ack);
        rq_req[0] = 1'b0;
        check("t4_timeout_cycles", 64'(t_ack - t_req), 64'd256);
        @(negedge clk);
        check("t4_busy_drop", 64'(busy), 64'd0);
        @(posedge clk); #1 mem_ready = 1'b1;
        @(posedge clk); #1 mem_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("t4_stale_busy", 64'(busy), 64'd0);

        // async reset during WAIT
        drive(1, 1'b1, 26'h1555555, 64'h5555_5555_5555_5555, 8'hFF);
        expect_txn(1, 64'h0, 1'b0);
        rq_req[1] = 1'b1;
        wait_mem_req("t5", t_req);
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b0;
        rq_req = '0;
        #1;
        check("t5_rst_busy", 64'(busy),     64'd0);
        check("t5_rst_rnw",  64'(mem_rnw),  64'd0);
        check("t5_rst_addr", 64'(mem_addr), 64'd0);
        check("t5_rst_din",  mem_din,       64'd0);
        check("t5_rst_be",   64'(mem_be),   64'd0);
        check("t5_rst_dout", rq_dout,       64'd0);
        check("t5_rst_mreq", 64'(mem_req),  64'd0);
        sb.delete();
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 mem_ready = 1'b1;
        @(posedge clk); #1 mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_idle_after_stale", 64'(busy), 64'd0);
        expect_txn(1, 64'h5A5A_A5A5_0F0F_F0F0, 1'b0);
        rq_req[1] = 1'b1;
        wait_mem_req("t5b", t_req);
        respond(2, 64'h5A5A_A5A5_0F0F_F0F0, 1'b1, t_rdy);
        wait_ack("t5b", 10, t_ack);
        rq_req[1] = 1'b0;

        // ready in the watchdog expiry cycle is a success
        drive(2, 1'b1, 26'h0333333, 64'h0, 8'hF0);
        expect_txn(2, 64'hFEED_FACE_CAFE_F00D, 1'b0);
        rq_req[2] = 1'b1;
        wait_mem_req("t6", t_req);
        respond(255, 64'hFEED_FACE_CAFE_F00D, 1'b1, t_rdy);
        wait_ack("t6", 10, t_ack);
        rq_req[2] = 1'b0;
        check("t6_ack_latency", 64'(t_ack - t_rdy), 64'(RD_SKEW + 1));
        @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
